// File: rtl/pc_seq_if.sv
// Fetch-side bundle for pc_seq: redirect/stall inputs from decode, imem handshake, PC outputs.
interface pc_seq_if #(parameter int WIDTH = 32);
  logic             i_stall;
  logic             i_branch;
  logic [WIDTH-1:0] i_branch_target;
  logic             i_jump;
  logic [WIDTH-1:0] i_jump_target;
  logic             i_exc;
  logic             i_eret;
  logic             i_imem_ack;
  logic             o_imem_req;
  logic [WIDTH-1:0] o_pc;
  logic [WIDTH-1:0] o_pc_next_seq;
  logic             o_fetch_valid;
  logic [WIDTH-1:0] o_epc;
  logic             o_redirect_pending;

  modport slave (
    input  i_stall, i_branch, i_branch_target, i_jump, i_jump_target,
           i_exc, i_eret, i_imem_ack,
    output o_imem_req, o_pc, o_pc_next_seq, o_fetch_valid, o_epc, o_redirect_pending
  );

  modport master (
    output i_stall, i_branch, i_branch_target, i_jump, i_jump_target,
           i_exc, i_eret, i_imem_ack,
    input  o_imem_req, o_pc, o_pc_next_seq, o_fetch_valid, o_epc, o_redirect_pending
  );
endinterface

// File: rtl/pc_seq.sv
// MIPS32 fetch PC sequencer: imem req/ack, prioritised redirects, EPC, pending-redirect buffer.
// Optional branch delay slot for jump/branch when PC_DELAY_SLOT_EN is defined.
module pc_seq #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int               STEP         = 4
) (
  input logic    i_clk,
  input logic    i_rst_n,
  pc_seq_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT} state_e;

  // Redirect priority codes: exc=3, eret=2, jump=1, branch=0.
  localparam logic [1:0] PRI_ERET = 2'd2;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [1:0]       pend_pri_q, pend_pri_d;
`ifdef PC_DELAY_SLOT_EN
  logic             armed_q, armed_d;
`endif

  logic             req, adv;
  logic             win_vld;
  logic [1:0]       win_pri;
  logic [WIDTH-1:0] win_raw, win_tgt, pc_seq_nxt;

  assign pc_seq_nxt = pc_q + WIDTH'(STEP);

  always_comb begin
    win_vld = bus.i_exc | bus.i_eret | bus.i_jump | bus.i_branch;
    win_pri = 2'd0;
    win_raw = bus.i_branch_target;
    if (bus.i_exc) begin
      win_pri = 2'd3;
      win_raw = EXC_VECTOR;
    end else if (bus.i_eret) begin
      win_pri = PRI_ERET;
      win_raw = epc_q;
    end else if (bus.i_jump) begin
      win_pri = 2'd1;
      win_raw = bus.i_jump_target;
    end
    win_tgt = {win_raw[WIDTH-1:2], 2'b00};
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        req = ~bus.i_stall;
        if (req && !bus.i_imem_ack) state_d = S_WAIT;
      end
      S_WAIT: begin
        req = 1'b1;
        if (bus.i_imem_ack) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign adv = req & bus.i_imem_ack;

  always_comb begin
    pc_d       = pc_q;
    epc_d      = bus.i_exc ? pc_q : epc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    pend_pri_d = pend_pri_q;
`ifdef PC_DELAY_SLOT_EN
    armed_d    = armed_q;
    if (adv) begin
      // exc/eret go straight through; jump/branch take one delay-slot fetch first.
      if (win_vld && win_pri >= PRI_ERET) begin
        pc_d    = win_tgt;
        pend_d  = 1'b0;
        armed_d = 1'b0;
      end else if (pend_q && (armed_q || pend_pri_q >= PRI_ERET)) begin
        pc_d    = pend_tgt_q;
        pend_d  = 1'b0;
        armed_d = 1'b0;
      end else if (win_vld) begin
        pc_d       = pc_seq_nxt;
        pend_d     = 1'b1;
        pend_tgt_d = win_tgt;
        pend_pri_d = win_pri;
        armed_d    = 1'b1;
      end else begin
        pc_d    = pc_seq_nxt;
        armed_d = pend_q;
      end
    end else if (win_vld && (!pend_q || win_pri >= pend_pri_q)) begin
      pend_d     = 1'b1;
      pend_tgt_d = win_tgt;
      pend_pri_d = win_pri;
    end
`else
    if (adv) begin
      pend_d = 1'b0;
      if (win_vld)     pc_d = win_tgt;
      else if (pend_q) pc_d = pend_tgt_q;
      else             pc_d = pc_seq_nxt;
    end else if (win_vld && (!pend_q || win_pri >= pend_pri_q)) begin
      pend_d     = 1'b1;
      pend_tgt_d = win_tgt;
      pend_pri_d = win_pri;
    end
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      pend_pri_q <= 2'd0;
`ifdef PC_DELAY_SLOT_EN
      armed_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      pend_pri_q <= pend_pri_d;
`ifdef PC_DELAY_SLOT_EN
      armed_q    <= armed_d;
`endif
    end
  end

  assign bus.o_imem_req         = req;
  assign bus.o_pc               = pc_q;
  assign bus.o_pc_next_seq      = pc_seq_nxt;
  assign bus.o_fetch_valid      = adv;
  assign bus.o_epc              = epc_q;
  assign bus.o_redirect_pending = pend_q;
endmodule

// File: tb/tb_pc_seq.sv
// Vector-table bench for pc_seq: per-cycle req/fetch_valid checks plus a scoreboard of post-edge PC/pending/EPC.
module tb_pc_seq;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;

  pc_seq_if #(.WIDTH(32)) bus();
  pc_seq dut (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        ack, stall, exc, eret, jmp, br;
    logic [31:0] jt, bt;
    logic        e_req, e_fv;
    logic [31:0] e_pc;
    logic        e_pend;
    logic [31:0] e_epc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic [31:0] epc;
    int          idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(bit ack, bit stall, bit exc, bit eret, bit jmp, logic [31:0] jt,
                             bit br, logic [31:0] bt, bit e_req, bit e_fv, logic [31:0] e_pc,
                             bit e_pend, logic [31:0] e_epc);
    vec_t r;
    r.ack = ack; r.stall = stall; r.exc = exc; r.eret = eret; r.jmp = jmp; r.jt = jt;
    r.br = br; r.bt = bt; r.e_req = e_req; r.e_fv = e_fv; r.e_pc = e_pc;
    r.e_pend = e_pend; r.e_epc = e_epc;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    bus.i_imem_ack      = x.ack;
    bus.i_stall         = x.stall;
    bus.i_exc           = x.exc;
    bus.i_eret          = x.eret;
    bus.i_jump          = x.jmp;
    bus.i_jump_target   = x.jt;
    bus.i_branch        = x.br;
    bus.i_branch_target = x.bt;
  endtask

  // Called 1 time unit after a rising edge; ends 1 time unit after the next one.
  task automatic run_vec(input int i, input vec_t x);
    exp_t e;
    drive(x);
    #3;
    chk($sformatf("v%0d.req", i), 32'(bus.o_imem_req), 32'(x.e_req));
    chk($sformatf("v%0d.fetch_valid", i), 32'(bus.o_fetch_valid), 32'(x.e_fv));
    sb.push_back('{pc: x.e_pc, pend: x.e_pend, epc: x.e_epc, idx: i});
    @(posedge i_clk);
    #1;
    e = sb.pop_front();
    chk($sformatf("v%0d.pc", e.idx), bus.o_pc, e.pc);
    chk($sformatf("v%0d.pending", e.idx), 32'(bus.o_redirect_pending), 32'(e.pend));
    chk($sformatf("v%0d.epc", e.idx), bus.o_epc, e.epc);
  endtask

  localparam logic [31:0] RV = 32'hBFC0_0000;
  localparam logic [31:0] EV = 32'hBFC0_0380;

  initial begin
    // Reset holds even with ack and a jump asserted.
    drive(v(1,0,0,0,1,32'h400,0,0, 0,0,0,0,0));
    i_rst_n = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    chk("rst.pc", bus.o_pc, RV);
    chk("rst.req", 32'(bus.o_imem_req), 32'd0);
    chk("rst.pending", 32'(bus.o_redirect_pending), 32'd0);
    chk("rst.epc", bus.o_epc, 32'd0);
    i_rst_n = 1'b1;

`ifdef PC_DELAY_SLOT_EN
    tbl.push_back(v(1,0,0,0,0,0,0,0,         0,0,RV,0,0));
    tbl.push_back(v(1,0,0,0,1,32'h100,0,0,   1,1,32'hBFC0_0004,1,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,         1,1,32'h100,0,0));
    tbl.push_back(v(1,0,0,0,0,0,1,32'h200,   1,1,32'h104,1,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,         1,1,32'h200,0,0));
    tbl.push_back(v(1,0,0,0,0,0,1,32'h300,   1,1,32'h204,1,0));
    tbl.push_back(v(1,0,1,0,0,0,0,0,         1,1,EV,0,32'h204));
    tbl.push_back(v(1,0,0,0,0,0,0,0,         1,1,32'hBFC0_0384,0,32'h204));
    foreach (tbl[i]) run_vec(i, tbl[i]);
`else
    tbl.push_back(v(1,0,0,0,0,0,0,0,                 0,0,RV,0,0));            // 0 IDLE
    tbl.push_back(v(1,0,0,0,0,0,0,0,                 1,1,32'hBFC0_0004,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,                 1,1,32'hBFC0_0008,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                 1,0,32'hBFC0_0008,0,0)); // 3 -> WAIT
    tbl.push_back(v(0,1,0,0,0,0,0,0,                 1,0,32'hBFC0_0008,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,                 1,0,32'hBFC0_0008,0,0));
    tbl.push_back(v(1,1,0,0,0,0,0,0,                 1,1,32'hBFC0_000C,0,0));
    tbl.push_back(v(1,1,0,0,0,0,0,0,                 0,0,32'hBFC0_000C,0,0)); // 7 stalled RUN
    tbl.push_back(v(1,0,0,0,1,32'h100,0,0,           1,1,32'h100,0,0));
    tbl.push_back(v(1,0,0,0,1,32'h400,1,32'h200,     1,1,32'h400,0,0));       // 9 jump beats branch
    tbl.push_back(v(1,0,0,0,1,32'h100,0,0,           1,1,32'h100,0,0));
    tbl.push_back(v(1,0,1,0,1,32'h400,1,32'h200,     1,1,EV,0,32'h100));      // 11 exc wins
    tbl.push_back(v(1,0,0,0,1,32'h100,0,0,           1,1,32'h100,0,32'h100));
    tbl.push_back(v(0,0,0,0,0,0,1,32'h203,           1,0,32'h100,1,32'h100)); // 13 buffered
    tbl.push_back(v(0,0,0,0,1,32'h300,0,0,           1,0,32'h100,1,32'h100));
    tbl.push_back(v(1,0,0,0,0,0,0,0,                 1,1,32'h300,0,32'h100));
    tbl.push_back(v(0,0,0,0,1,32'h500,0,0,           1,0,32'h300,1,32'h100));
    tbl.push_back(v(0,0,0,0,0,0,1,32'h600,           1,0,32'h300,1,32'h100)); // 17 lower prio dropped
    tbl.push_back(v(1,0,0,0,0,0,0,0,                 1,1,32'h500,0,32'h100));
    tbl.push_back(v(1,0,0,0,1,32'h100,0,0,           1,1,32'h100,0,32'h100));
    tbl.push_back(v(0,0,0,0,0,0,1,32'h203,           1,0,32'h100,1,32'h100));
    tbl.push_back(v(1,0,0,0,0,0,0,0,                 1,1,32'h200,0,32'h100)); // 21 masked
    tbl.push_back(v(1,0,0,0,1,32'h1000,0,0,          1,1,32'h1000,0,32'h100));
    tbl.push_back(v(1,0,1,0,0,0,0,0,                 1,1,EV,0,32'h1000));
    tbl.push_back(v(1,0,0,1,0,0,0,0,                 1,1,32'h1000,0,32'h1000)); // 24 eret
    tbl.push_back(v(1,0,0,0,1,32'h2000,0,0,          1,1,32'h2000,0,32'h1000));
    tbl.push_back(v(1,0,1,1,0,0,0,0,                 1,1,EV,0,32'h2000));     // 26 exc over eret
    tbl.push_back(v(1,0,0,1,0,0,0,0,                 1,1,32'h2000,0,32'h2000));
    tbl.push_back(v(1,0,0,0,1,32'hFFFF_FFFC,0,0,     1,1,32'hFFFF_FFFC,0,32'h2000));
    tbl.push_back(v(1,0,0,0,0,0,0,0,                 1,1,32'h0,0,32'h2000));  // 29 wrap
    tbl.push_back(v(0,0,0,0,0,0,1,32'h800,           1,0,32'h0,1,32'h2000));  // 30 pending in WAIT
    for (int i = 0; i < 29; i++) run_vec(i, tbl[i]);
    chk("wrap.pc_next_seq", bus.o_pc_next_seq, 32'h0);
    for (int i = 29; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // Reset mid-flight discards the WAIT state and the buffered branch.
    i_rst_n = 1'b0;
    drive(v(1,0,0,0,1,32'h400,0,0, 0,0,0,0,0));
    @(posedge i_clk);
    #1;
    chk("midrst.pc", bus.o_pc, RV);
    chk("midrst.pending", 32'(bus.o_redirect_pending), 32'd0);
    chk("midrst.req", 32'(bus.o_imem_req), 32'd0);
    chk("midrst.epc", bus.o_epc, 32'd0);
    i_rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
